tl_a_channel_rr_arbiter: RTL and testbench
==========================================

// Module: tl_a_channel_rr_arbiter
// PURPOSE
// - Shares one TileLink A channel between N upstream requesters, and routes the returning D channel back to them.
// - Arbitration is round-robin and burst-locked.
// - The requester index is prepended to the source ID on A and decoded from the source ID on D.
// - Sits in front of the repeater/monitor pair on the peripheral port. Output A traffic must stay legal to the TL monitor.
// PARAMETERS
// N        2   number of requesters (2..8); IDX_W = max(1,$clog2(N)) is a localparam
// SRC_W    4   per-requester source ID width
// ADDR_W  32   address width
// DATA_W  64   data width in bits; DATA_BYTES = DATA_W/8
// PORTS
// clock         in   1                  single clock, all state on posedge
// reset_n       in   1                  asynchronous reset, active-low
// in_a_valid    in   N                  per-requester A valid
// in_a_ready    out  N                  per-requester A ready
// in_a_opcode   in   N*3                packed, requester i at [3i+:3]
// in_a_size     in   N*4                log2 bytes, packed
// in_a_source   in   N*SRC_W            packed
// in_a_address  in   N*ADDR_W           packed
// in_a_mask     in   N*DATA_BYTES       packed
// in_a_data     in   N*DATA_W           packed
// a_valid/a_ready  out/in  1            shared A handshake
// a_opcode,a_size,a_address,a_mask,a_data  out  as above  granted requester's fields
// a_source      out  IDX_W+SRC_W        {grant_idx, in_a_source[grant]}
// d_valid/d_ready  in/out  1            shared D handshake
// d_source      in   IDX_W+SRC_W        upper IDX_W bits select the requester
// in_d_valid    out  N                  d_valid steered to the selected requester
// in_d_ready    in   N                  per-requester D ready
// d_route_err   out  1                  sticky: a D beat arrived with index >= N
// BEHAVIOUR
// - State: fsm {IDLE,BURST}, rr_ptr[IDX_W], lock_idx[IDX_W], beats_left[8:0], hold.
// - Reset values: fsm=IDLE, rr_ptr=0, lock_idx=0, beats_left=0, hold=0, d_route_err=0.
// - While reset_n=0: a_valid=0, in_a_ready=0, in_d_valid=0, d_ready=0.
// - Beat count of a message:
//   - opcode in {0,1,2,3} (carries data): max(1, (1<<size)/DATA_BYTES).
//   - any other opcode: 1.
// - IDLE, hold=0: grant = first i with in_a_valid[i], scanning rr_ptr, rr_ptr+1, ... mod N. Combinational, zero latency.
// - IDLE, hold=1: grant = lock_idx.
// - Datapath: a_valid = in_a_valid[grant]; in_a_ready[grant] = a_ready; all other in_a_ready = 0.
// - No requester valid: a_valid=0 and the grant value is don't-care.
// - Irrevocability: a_valid=1 and a_ready=0 sets hold=1 and lock_idx=grant, so the grant cannot move.
//   hold clears on the next fire.
// - Fire (a_valid & a_ready) in IDLE:
//   - beats==1: rr_ptr <= (grant+1) mod N; stay IDLE.
//   - beats>1: lock_idx <= grant; beats_left <= beats-1; go BURST.
// - BURST: only lock_idx is connected. Each fire decrements beats_left.
//   On the fire that makes beats_left 0: go IDLE, rr_ptr <= (lock_idx+1) mod N, hold <= 0.
// - In BURST, opcode/size of follow-on beats are passed through unchanged and not re-decoded.
// - Simultaneous requests: exactly one grant. Every requester is served within N messages.
// - D channel: idx = d_source[SRC_W+:IDX_W].
//   - idx < N: in_d_valid[idx] = d_valid; d_ready = in_d_ready[idx].
//   - idx >= N (only possible when N is not a power of 2): d_ready=1, beat dropped, d_route_err <= 1 on d_valid.
// - D routing is purely combinational and fully independent of the A-side state.
// - Reset asserted mid-burst: immediate return to reset values. A partially sent burst is the system's responsibility.
// TESTING
// - Reset: reset_n=0 with all in_a_valid=1 -> a_valid=0, in_a_ready=0.
//   Release -> requester 0 is granted first.
// - Round-robin: N=2, both valid, Get (opcode 4) size 3, a_ready=1 -> grants alternate 0,1,0,1.
//   a_source = {idx,src}.
// - Burst lock: req0 PutFull size 5 (4 beats) and req1 valid -> 4 consecutive req0 beats, then req1.
//   in_a_ready[1]=0 throughout the burst.
// - Backpressure: a_ready=0 for 5 cycles while req1 is pending and req0 granted -> grant stays 0.
//   a_opcode/a_address stay stable; req0 fires when a_ready rises.
// - D routing: d_source={1,4'h7}, in_d_ready=2'b10 -> in_d_valid=2'b10, d_ready=1.
//   With N=3 and idx=3 -> d_ready=1, d_route_err sets and stays set.
// - Mid-burst reset: assert reset_n=0 after beat 2 of 4 -> fsm IDLE, rr_ptr=0.
//   After release a new arbitration starts at 0.

Source files
------------

// File: rtl/tl_a_channel_rr_arbiter_if.sv
// tl_a_channel_rr_arbiter_if: requester-side and shared-side TileLink A/D signals for the arbiter
// Ports: none (signal bundle only).
// Packed per-requester fields: requester i occupies slice i of each in_* vector.
// Modports: slave = arbiter view, master = environment view.
interface tl_a_channel_rr_arbiter_if #(
  parameter int N      = 2,
  parameter int SRC_W  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  localparam int IDX_W = N > 1 ? $clog2(N) : 1;
  localparam int DB    = DATA_W / 8;
  logic [N-1:0]           in_a_valid, in_a_ready;
  logic [N*3-1:0]         in_a_opcode;
  logic [N*4-1:0]         in_a_size;
  logic [N*SRC_W-1:0]     in_a_source;
  logic [N*ADDR_W-1:0]    in_a_address;
  logic [N*DB-1:0]        in_a_mask;
  logic [N*DATA_W-1:0]    in_a_data;
  logic                   a_valid, a_ready;
  logic [2:0]             a_opcode;
  logic [3:0]             a_size;
  logic [IDX_W+SRC_W-1:0] a_source;
  logic [ADDR_W-1:0]      a_address;
  logic [DB-1:0]          a_mask;
  logic [DATA_W-1:0]      a_data;
  logic                   d_valid, d_ready;
  logic [IDX_W+SRC_W-1:0] d_source;
  logic [N-1:0]           in_d_valid, in_d_ready;
  logic                   d_route_err;
  modport slave (
    input  in_a_valid, in_a_opcode, in_a_size, in_a_source, in_a_address, in_a_mask, in_a_data,
    input  a_ready, d_valid, d_source, in_d_ready,
    output in_a_ready, a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
    output d_ready, in_d_valid, d_route_err
  );
  modport master (
    output in_a_valid, in_a_opcode, in_a_size, in_a_source, in_a_address, in_a_mask, in_a_data,
    output a_ready, d_valid, d_source, in_d_ready,
    input  in_a_ready, a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
    input  d_ready, in_d_valid, d_route_err
  );
endinterface

// File: rtl/tl_a_channel_rr_arbiter.sv
// tl_a_channel_rr_arbiter: round-robin, burst-locked sharing of one TileLink A channel with D routing
// Ports: clock, reset_n (async, active-low), bus (slave modport): N upstream A requesters,
// shared A output with {index,source} IDs, shared D input steered back by the index in d_source,
// and a sticky d_route_err for D beats carrying an index >= N.
module tl_a_channel_rr_arbiter #(
  parameter int N      = 2,
  parameter int SRC_W  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input logic                     clock,
  input logic                     reset_n,
  tl_a_channel_rr_arbiter_if.slave bus
);
  localparam int IDX_W = N > 1 ? $clog2(N) : 1;
  localparam int DB    = DATA_W / 8;
  typedef enum logic {IDLE, BURST} state_e;
  state_e            fsm_q, fsm_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d, lock_idx_q, lock_idx_d, rr_grant, grant, scan, d_idx;
  logic [8:0]        beats_left_q, beats_left_d;
  logic              hold_q, hold_d, err_q, err_d, found, fire, d_ok;
  logic [16:0]       bytes, beats;
  logic [2:0]        opc [N];
  logic [3:0]        siz [N];
  logic [SRC_W-1:0]  src [N];
  logic [ADDR_W-1:0] adr [N];
  logic [DB-1:0]     msk [N];
  logic [DATA_W-1:0] dat [N];
  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign opc[i] = bus.in_a_opcode[3*i +: 3];
    assign siz[i] = bus.in_a_size[4*i +: 4];
    assign src[i] = bus.in_a_source[SRC_W*i +: SRC_W];
    assign adr[i] = bus.in_a_address[ADDR_W*i +: ADDR_W];
    assign msk[i] = bus.in_a_mask[DB*i +: DB];
    assign dat[i] = bus.in_a_data[DATA_W*i +: DATA_W];
  end
  function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] x);
    return (int'(x) == N - 1) ? '0 : x + 1'b1;
  endfunction
  // First valid requester at or after rr_ptr, wrapping modulo N.
  always_comb begin
    rr_grant = rr_ptr_q;
    found    = 1'b0;
    scan     = '0;
    for (int k = 0; k < N; k++) begin
      scan = IDX_W'((int'(rr_ptr_q) + k) % N);
      if (!found && bus.in_a_valid[scan]) begin
        rr_grant = scan;
        found    = 1'b1;
      end
    end
  end
  // A stalled or bursting grant is pinned to lock_idx so it can never move mid-message.
  assign grant         = (fsm_q == BURST || hold_q) ? lock_idx_q : rr_grant;
  assign bus.a_valid   = reset_n & bus.in_a_valid[grant];
  assign bus.in_a_ready = (reset_n & bus.a_ready) ? N'(1) << grant : '0;
  assign bus.a_opcode  = opc[grant];
  assign bus.a_size    = siz[grant];
  assign bus.a_source  = {grant, src[grant]};
  assign bus.a_address = adr[grant];
  assign bus.a_mask    = msk[grant];
  assign bus.a_data    = dat[grant];
  assign fire          = bus.a_valid & bus.a_ready;
  // Data-carrying opcodes (0..3) span (1<<size)/DATA_BYTES beats, at least one.
  assign bytes = 17'(1) << siz[grant];
  assign beats = (opc[grant] < 3'd4 && bytes > 17'(DB)) ? bytes / 17'(DB) : 17'd1;
  always_comb begin
    fsm_d        = fsm_q;
    rr_ptr_d     = rr_ptr_q;
    lock_idx_d   = lock_idx_q;
    beats_left_d = beats_left_q;
    hold_d       = hold_q;
    if (fsm_q == IDLE) begin
      if (fire) begin
        hold_d = 1'b0;
        if (beats == 17'd1) rr_ptr_d = nxt(grant);
        else begin
          lock_idx_d   = grant;
          beats_left_d = 9'(beats - 17'd1);
          fsm_d        = BURST;
        end
      end else if (bus.a_valid) begin
        hold_d     = 1'b1;
        lock_idx_d = grant;
      end
    end else if (fire) begin
      beats_left_d = beats_left_q - 9'd1;
      if (beats_left_q == 9'd1) begin
        fsm_d    = IDLE;
        rr_ptr_d = nxt(lock_idx_q);
        hold_d   = 1'b0;
      end
    end
  end
  // D routing depends only on d_source; out-of-range indices are accepted and dropped.
  assign d_idx           = bus.d_source[SRC_W +: IDX_W];
  assign d_ok            = int'(d_idx) < N;
  assign bus.in_d_valid  = (reset_n & d_ok & bus.d_valid) ? N'(1) << d_idx : '0;
  assign bus.d_ready     = reset_n & (d_ok ? bus.in_d_ready[d_idx] : 1'b1);
  assign err_d           = err_q | (bus.d_valid & ~d_ok);
  assign bus.d_route_err = err_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q        <= IDLE;
      rr_ptr_q     <= '0;
      lock_idx_q   <= '0;
      beats_left_q <= '0;
      hold_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_idx_q   <= lock_idx_d;
      beats_left_q <= beats_left_d;
      hold_q       <= hold_d;
      err_q        <= err_d;
    end
  end
endmodule

// File: tb/tb_tl_a_channel_rr_arbiter.sv
// tb_tl_a_channel_rr_arbiter: directed checks of arbitration, burst lock, backpressure and D routing
module tb_tl_a_channel_rr_arbiter;
  logic clock, reset_n;
  int   n_chk = 0, n_fail = 0;
  tl_a_channel_rr_arbiter_if #(.N(2)) b2 ();
  tl_a_channel_rr_arbiter_if #(.N(3)) b3 ();
  tl_a_channel_rr_arbiter #(.N(2)) dut2 (.clock(clock), .reset_n(reset_n), .bus(b2));
  tl_a_channel_rr_arbiter #(.N(3)) dut3 (.clock(clock), .reset_n(reset_n), .bus(b3));
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    reset_n         = 1'b0;
    b2.in_a_valid   = 2'b11;
    b2.in_a_opcode  = {3'd4, 3'd4};
    b2.in_a_size    = {4'd3, 4'd3};
    b2.in_a_source  = {4'h5, 4'h3};
    b2.in_a_address = {32'h200, 32'h100};
    b2.in_a_mask    = '1;
    b2.in_a_data    = {64'hB, 64'hA};
    b2.a_ready      = 1'b1;
    b2.d_valid      = 1'b0;
    b2.d_source     = '0;
    b2.in_d_ready   = '0;
    b3.in_a_valid   = 3'b000;
    b3.in_a_opcode  = {3'd4, 3'd4, 3'd4};
    b3.in_a_size    = {4'd3, 4'd3, 4'd3};
    b3.in_a_source  = {4'h9, 4'h5, 4'h3};
    b3.in_a_address = {32'h300, 32'h200, 32'h100};
    b3.in_a_mask    = '1;
    b3.in_a_data    = '0;
    b3.a_ready      = 1'b1;
    b3.d_valid      = 1'b0;
    b3.d_source     = '0;
    b3.in_d_ready   = '0;
    tick;
    tick;
    chk("rst_a_valid", b2.a_valid, 0);
    chk("rst_in_a_ready", b2.in_a_ready, 0);
    b2.d_valid = 1'b1; b2.d_source = 5'h17; b2.in_d_ready = 2'b10;
    #1;
    chk("rst_in_d_valid", b2.in_d_valid, 0);
    chk("rst_d_ready", b2.d_ready, 0);
    b2.d_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    chk("rel_a_valid", b2.a_valid, 1);
    chk("rel_src", b2.a_source, 5'h03);
    chk("rel_in_a_ready", b2.in_a_ready, 2'b01);
    for (int i = 0; i < 4; i++) begin
      chk("rr_src", b2.a_source, (i % 2) ? 5'h15 : 5'h03);
      chk("rr_addr", b2.a_address, (i % 2) ? 32'h200 : 32'h100);
      chk("rr_in_a_ready", b2.in_a_ready, (i % 2) ? 2'b10 : 2'b01);
      tick;
    end
    b2.in_a_opcode = {3'd4, 3'd0};
    b2.in_a_size   = {4'd3, 4'd5};
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("burst_src", b2.a_source, 5'h03);
      chk("burst_in_a_ready", b2.in_a_ready, 2'b01);
      tick;
    end
    chk("after_burst_src", b2.a_source, 5'h15);
    tick;
    b2.in_a_size = {4'd3, 4'd2};
    #1;
    chk("small_put_src", b2.a_source, 5'h03);
    tick;
    chk("small_put_next", b2.a_source, 5'h15);
    tick;
    b2.in_a_opcode = {3'd4, 3'd4};
    b2.in_a_size   = {4'd3, 4'd3};
    b2.a_ready     = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_src", b2.a_source, 5'h03);
      chk("bp_opcode", b2.a_opcode, 3'd4);
      chk("bp_addr", b2.a_address, 32'h100);
      chk("bp_in_a_ready", b2.in_a_ready, 2'b00);
      tick;
    end
    b2.a_ready = 1'b1;
    #1;
    chk("bp_release_rdy", b2.in_a_ready, 2'b01);
    tick;
    chk("bp_after_src", b2.a_source, 5'h15);
    b2.a_ready    = 1'b0;
    b2.in_a_valid = 2'b01;
    #1;
    chk("hold_first", b2.a_source, 5'h03);
    tick;
    b2.in_a_valid = 2'b11;
    #1;
    chk("hold_pinned", b2.a_source, 5'h03);
    tick;
    chk("hold_pinned2", b2.a_source, 5'h03);
    b2.a_ready = 1'b1;
    tick;
    chk("hold_released", b2.a_source, 5'h15);
    b2.d_valid = 1'b1; b2.d_source = 5'h17; b2.in_d_ready = 2'b10;
    #1;
    chk("d1_in_d_valid", b2.in_d_valid, 2'b10);
    chk("d1_d_ready", b2.d_ready, 1);
    b2.d_source = 5'h07;
    #1;
    chk("d0_in_d_valid", b2.in_d_valid, 2'b01);
    chk("d0_d_ready", b2.d_ready, 0);
    b2.d_valid = 1'b0;
    b2.in_a_valid  = 2'b10;
    b2.in_a_opcode = {3'd0, 3'd4};
    b2.in_a_size   = {4'd5, 4'd3};
    tick;
    tick;
    reset_n = 1'b0;
    #1;
    chk("midrst_a_valid", b2.a_valid, 0);
    chk("midrst_in_a_ready", b2.in_a_ready, 0);
    tick;
    reset_n       = 1'b1;
    b2.in_a_valid = 2'b01;
    #1;
    chk("midrst_idle", b2.a_valid, 1);
    b2.in_a_valid = 2'b11;
    #1;
    chk("midrst_ptr", b2.a_source, 5'h03);
    b3.in_a_valid = 3'b111;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rr3_src", b3.a_source, (i % 3 == 0) ? 6'h03 : (i % 3 == 1) ? 6'h15 : 6'h29);
      tick;
    end
    b3.in_a_valid = 3'b000;
    b3.d_valid = 1'b1; b3.d_source = 6'h21; b3.in_d_ready = 3'b100;
    #1;
    chk("d3_in_d_valid", b3.in_d_valid, 3'b100);
    chk("d3_d_ready", b3.d_ready, 1);
    chk("d3_err_clear", b3.d_route_err, 0);
    b3.d_source = 6'h30; b3.in_d_ready = 3'b000;
    #1;
    chk("d3_bad_d_ready", b3.d_ready, 1);
    chk("d3_bad_in_d_valid", b3.in_d_valid, 3'b000);
    tick;
    chk("d3_err_set", b3.d_route_err, 1);
    b3.d_valid = 1'b0;
    tick;
    tick;
    chk("d3_err_sticky", b3.d_route_err, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
